// File: rtl/mux_sel_pkg.sv
// Shared constants, FSM state type and select decode for the mux select sequencer.
package mux_sel_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_CH-1:0] onehot8(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_find_first.sv
// Round-robin search: first set request bit at or above ptr, wrapping 7 -> 0.
module rr_find_first
    import mux_sel_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] pos;

    // Walking pos = ptr + i is the rotate; the first hit is the priority encode.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        pos   = '0;
        for (int i = 0; i < N_CH; i++) begin
            pos = ptr + SEL_W'(i);
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/mux_sel_rr_sequencer.sv
// Round-robin arbiter driving the 8:1 mux select for bounded bursts, with
// a valid/ready beat interface to the downstream consumer.
module mux_sel_rr_sequencer
    import mux_sel_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] select,
    output logic [N_CH-1:0]  grant,
    output logic             out_valid,
    output logic             burst_done
);

    localparam int              LAST_I = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;
    localparam logic [CNT_W-1:0] LAST  = LAST_I[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N_CH-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             win_found;
    logic [SEL_W-1:0] win_idx;
    logic             xfer;
    logic             at_limit;

    rr_find_first u_find (
        .req   (req),
        .ptr   (ptr_q),
        .found (win_found),
        .idx   (win_idx)
    );

    // Handshake: a beat moves on any cycle where out_valid && out_ready are both
    // high; out_valid follows the granted request live and never waits on ready.
    assign out_valid  = (state_q == BUSY) && req[sel_q];
    assign xfer       = out_valid && out_ready;
    assign at_limit   = (MAX_BURST != 0) && (cnt_q == LAST);

    assign select     = sel_q;
    assign grant      = grant_q;
    assign burst_done = done_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    grant_d = onehot8(win_idx);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A request drop and the last beat collapse into one release.
                if (!req[sel_q] || (xfer && at_limit)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                    done_d  = 1'b1;
                end else if (xfer && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_rr_sequencer.sv
// Directed bench for the round-robin mux select sequencer (MAX_BURST = 4).
module tb_mux_sel_rr_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] select;
    logic [7:0] grant;
    logic       out_valid;
    logic       burst_done;

    int n_tests;
    int n_fail;

    mux_sel_rr_sequencer #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .out_ready  (out_ready),
        .select     (select),
        .grant      (grant),
        .out_valid  (out_valid),
        .burst_done (burst_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample point sits 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves rst_n released at a sample point with no clock edge since.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        req       = 8'hFF;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        obs = {grant, select, out_valid, burst_done};
        n_tests++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", obs, 13'h0);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (grant !== 8'h00 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: grant=%h valid=%b expected 00/0", grant, out_valid);
        end
        #1;
        step();
        n_tests++;
        if (grant !== 8'h01 || select !== 3'd0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: grant=%h sel=%0d valid=%b expected 01/0/1",
                     grant, select, out_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [12:0] obs;
        logic [12:0] exp_v;
        int          ch;
        req       = 8'hFF;
        out_ready = 1'b1;
        do_reset();
        step();
        for (int g = 0; g < 9; g++) begin
            ch = g % 8;
            for (int b = 0; b < 4; b++) begin
                obs   = {grant, select, out_valid, burst_done};
                exp_v = {8'h01 << ch, 3'(ch), 1'b1, 1'b0};
                n_tests++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL rr_beat g%0d b%0d: got %h expected %h", g, b, obs, exp_v);
                end
                step();
            end
            obs   = {grant, out_valid, burst_done};
            exp_v = {3'b0, 8'h00, 1'b0, 1'b1};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rr_release g%0d: got %h expected %h", g, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_wrap_skip();
        req       = 8'b0010_0000;
        out_ready = 1'b1;
        do_reset();
        step();
        n_tests++;
        if (grant !== 8'h20) begin
            n_fail++;
            $display("FAIL wrap_first: grant=%h expected 20", grant);
        end
        repeat (4) step();
        n_tests++;
        if (burst_done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_release: burst_done=%b expected 1", burst_done);
        end
        req = 8'b0010_0001;
        step();
        n_tests++;
        if (grant !== 8'h01 || select !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_to_0: grant=%h sel=%0d expected 01/0", grant, select);
        end
        repeat (5) step();
        n_tests++;
        if (grant !== 8'h20 || select !== 3'd5) begin
            n_fail++;
            $display("FAIL wrap_then_5: grant=%h sel=%0d expected 20/5", grant, select);
        end
    endtask

    task automatic test_early_drop();
        req       = 8'h08;
        out_ready = 1'b1;
        do_reset();
        step();
        step();
        step();
        req = 8'h00;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || grant !== 8'h08) begin
            n_fail++;
            $display("FAIL drop_valid: valid=%b grant=%h expected 0/08", out_valid, grant);
        end
        step();
        n_tests++;
        if (burst_done !== 1'b1 || grant !== 8'h00) begin
            n_fail++;
            $display("FAIL drop_release: done=%b grant=%h expected 1/00", burst_done, grant);
        end
        req = 8'h18;
        step();
        n_tests++;
        if (grant !== 8'h10 || burst_done !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_ptr4: grant=%h done=%b expected 10/0", grant, burst_done);
        end
    endtask

    task automatic test_backpressure();
        int  beats;
        logic seen_done;
        req       = 8'h04;
        out_ready = 1'b0;
        do_reset();
        step();
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (grant !== 8'h04 || select !== 3'd2 || out_valid !== 1'b1 || burst_done !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold c%0d: grant=%h sel=%0d valid=%b done=%b",
                         c, grant, select, out_valid, burst_done);
            end
            step();
        end
        out_ready = 1'b1;
        beats     = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 20 && !seen_done; c++) begin
            if (burst_done) seen_done = 1'b1;
            else begin
                if (out_valid && out_ready) beats++;
                step();
            end
        end
        n_tests++;
        if (!seen_done || beats != 4) begin
            n_fail++;
            $display("FAIL bp_beats: beats=%0d done_seen=%b expected 4/1", beats, seen_done);
        end
    endtask

    task automatic test_mid_burst_reset();
        logic [12:0] obs;
        req       = 8'h20;
        out_ready = 1'b1;
        do_reset();
        repeat (5) step();
        req = 8'h40;
        step();
        n_tests++;
        if (grant !== 8'h40) begin
            n_fail++;
            $display("FAIL mrst_grant6: grant=%h expected 40", grant);
        end
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        obs = {grant, select, out_valid, burst_done};
        n_tests++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL mrst_async: got %h expected %h", obs, 13'h0);
        end
        req = 8'hFF;
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (grant !== 8'h01 || select !== 3'd0) begin
            n_fail++;
            $display("FAIL mrst_restart: grant=%h sel=%0d expected 01/0", grant, select);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_wrap_skip();
        test_early_drop();
        test_backpressure();
        test_mid_burst_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
